// File: rtl/sat_bin_pkg.sv
// Shared definitions for the clause-row driver: literal value width, outcome
// codes, freelitcnt chain encoding and the controller state enum.
package sat_bin_pkg;

  localparam int LIT_VAL_W = 3;

  localparam logic [1:0] RES_UNDET = 2'b00;
  localparam logic [1:0] RES_SAT   = 2'b01;
  localparam logic [1:0] RES_IMP   = 2'b10;
  localparam logic [1:0] RES_CONF  = 2'b11;

  // freelitcnt chain: 0 free, 1 free, two-or-more free; 3 never legal
  localparam logic [1:0] FLC_ZERO    = 2'd0;
  localparam logic [1:0] FLC_ONE     = 2'd1;
  localparam logic [1:0] FLC_MANY    = 2'd2;
  localparam logic [1:0] FLC_ILLEGAL = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_EVAL,
    ST_IMP,
    ST_IMP_CAP,
    ST_CONF,
    ST_DONE
  } state_t;

endpackage

// File: rtl/clause_eval_ctrl_sat_cnt.sv
// Saturating event counter: holds at all-ones instead of wrapping.
module sat_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Count one per inc cycle, stopping once every bit is set
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + CNT_ONE;
    end
  end

endmodule

// File: rtl/clause_eval_ctrl.sv
// Base-side driver for one lit4 clause row: writes the value vector into the
// row, reads back sat/freelitcnt, fires implication or conflict drive and
// returns the outcome and updated values through a start/done handshake.
module clause_eval_ctrl
  import sat_bin_pkg::*;
#(
  parameter int NUM_LITS = 4,
  parameter int CNT_W    = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start_i,
  output logic                          ready_o,
  input  logic [NUM_LITS*LIT_VAL_W-1:0] var_value_i,
  output logic                          done_o,
  input  logic                          done_ack_i,
  output logic [1:0]                    result_o,
  output logic [NUM_LITS*LIT_VAL_W-1:0] var_value_o,
  output logic                          err_o,
  output logic [CNT_W-1:0]              imp_cnt_o,
  output logic [CNT_W-1:0]              conf_cnt_o,
  output logic                          wr_o,
  output logic [NUM_LITS*LIT_VAL_W-1:0] var_value_frombase_o,
  input  logic [NUM_LITS*LIT_VAL_W-1:0] var_value_tobase_i,
  output logic [1:0]                    freelitcnt_pre_o,
  input  logic [1:0]                    freelitcnt_next_i,
  output logic                          imp_drv_o,
  input  logic                          cclause_i,
  output logic                          cclause_drv_o,
  input  logic                          clausesat_i
);

  localparam int VEC_W = NUM_LITS * LIT_VAL_W;

  state_t           state;
  state_t           next_state;
  logic [VEC_W-1:0] vreg;
  logic [1:0]       result;
  logic             err;
  logic             imp_inc;
  logic             conf_inc;

  assign freelitcnt_pre_o     = FLC_ZERO;
  assign var_value_frombase_o = vreg;
  assign var_value_o          = vreg;
  assign result_o             = result;
  assign err_o                = err;

  // State register; reset drops straight back to idle, cutting any drive pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state: sat beats free-literal count; 0 free is conflict, 1 is implication
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (start_i) begin
          next_state = ST_LOAD;
        end
      end
      ST_LOAD: next_state = ST_EVAL;
      ST_EVAL: begin
        if (clausesat_i) begin
          next_state = ST_DONE;
        end else begin
          case (freelitcnt_next_i)
            FLC_ZERO: next_state = ST_CONF;
            FLC_ONE:  next_state = ST_IMP;
            default:  next_state = ST_DONE;
          endcase
        end
      end
      ST_IMP:     next_state = ST_IMP_CAP;
      ST_IMP_CAP: next_state = ST_DONE;
      ST_CONF:    next_state = ST_DONE;
      ST_DONE: begin
        if (done_ack_i) begin
          next_state = ST_IDLE;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Moore outputs: each drive strobe belongs to exactly one single-cycle state
  always_comb begin
    ready_o       = 1'b0;
    done_o        = 1'b0;
    wr_o          = 1'b0;
    imp_drv_o     = 1'b0;
    cclause_drv_o = 1'b0;
    imp_inc       = 1'b0;
    conf_inc      = 1'b0;
    case (state)
      ST_IDLE:    ready_o       = 1'b1;
      ST_LOAD:    wr_o          = 1'b1;
      ST_IMP:     imp_drv_o     = 1'b1;
      ST_IMP_CAP: imp_inc       = 1'b1;
      ST_CONF: begin
        cclause_drv_o = 1'b1;
        conf_inc      = 1'b1;
      end
      ST_DONE:    done_o        = 1'b1;
      default: ;
    endcase
  end

  // Value register, outcome register and sticky protocol error
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vreg   <= '0;
      result <= RES_UNDET;
      err    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_i) begin
            vreg   <= var_value_i;
            result <= RES_UNDET;
          end
        end
        ST_EVAL: begin
          if (clausesat_i) begin
            result <= RES_SAT;
          end else if (freelitcnt_next_i == FLC_ILLEGAL) begin
            err    <= 1'b1;
            result <= RES_UNDET;
          end else if (freelitcnt_next_i == FLC_MANY) begin
            result <= RES_UNDET;
          end
        end
        ST_IMP_CAP: begin
          vreg   <= var_value_tobase_i;
          result <= RES_IMP;
        end
        ST_CONF: begin
          result <= RES_CONF;
          if (!cclause_i) begin
            err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  sat_cnt #(.CNT_W(CNT_W)) u_imp_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (imp_inc),
    .count (imp_cnt_o)
  );

  sat_cnt #(.CNT_W(CNT_W)) u_conf_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (conf_inc),
    .count (conf_cnt_o)
  );

endmodule

// File: tb/tb_clause_eval_ctrl.sv
// Self-checking bench for clause_eval_ctrl. Counters are built 2 bits wide so
// saturation is reachable quickly. Latency N means done_o is first seen in
// the Nth cycle after the accept edge (the LOAD cycle being cycle 1).
module tb_clause_eval_ctrl;
  import sat_bin_pkg::*;

  localparam int NUM_LITS = 4;
  localparam int CNT_W    = 2;
  localparam int VEC_W    = NUM_LITS * LIT_VAL_W;
  localparam int CNT_MAX  = 3;

  logic             clk;
  logic             rst;
  logic             start_i;
  logic             ready_o;
  logic [VEC_W-1:0] var_value_i;
  logic             done_o;
  logic             done_ack_i;
  logic [1:0]       result_o;
  logic [VEC_W-1:0] var_value_o;
  logic             err_o;
  logic [CNT_W-1:0] imp_cnt_o;
  logic [CNT_W-1:0] conf_cnt_o;
  logic             wr_o;
  logic [VEC_W-1:0] var_value_frombase_o;
  logic [VEC_W-1:0] var_value_tobase_i;
  logic [1:0]       freelitcnt_pre_o;
  logic [1:0]       freelitcnt_next_i;
  logic             imp_drv_o;
  logic             cclause_i;
  logic             cclause_drv_o;
  logic             clausesat_i;

  logic [VEC_W-1:0] row_val;
  logic [VEC_W-1:0] row_imp_val;

  int compared   = 0;
  int mismatched = 0;
  int imp_model  = 0;
  int conf_model = 0;

  typedef struct {
    logic [VEC_W-1:0] vin;
    logic             sat;
    logic [1:0]       flc;
    logic             cclause;
    logic [VEC_W-1:0] imp_val;
    logic [1:0]       exp_res;
    int               exp_lat;
    logic [VEC_W-1:0] exp_val;
    logic             exp_err;
  } vec_t;

  vec_t vecs[8];
  vec_t v_imp;
  vec_t v_illegal;

  clause_eval_ctrl #(.NUM_LITS(NUM_LITS), .CNT_W(CNT_W)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .start_i              (start_i),
    .ready_o              (ready_o),
    .var_value_i          (var_value_i),
    .done_o               (done_o),
    .done_ack_i           (done_ack_i),
    .result_o             (result_o),
    .var_value_o          (var_value_o),
    .err_o                (err_o),
    .imp_cnt_o            (imp_cnt_o),
    .conf_cnt_o           (conf_cnt_o),
    .wr_o                 (wr_o),
    .var_value_frombase_o (var_value_frombase_o),
    .var_value_tobase_i   (var_value_tobase_i),
    .freelitcnt_pre_o     (freelitcnt_pre_o),
    .freelitcnt_next_i    (freelitcnt_next_i),
    .imp_drv_o            (imp_drv_o),
    .cclause_i            (cclause_i),
    .cclause_drv_o        (cclause_drv_o),
    .clausesat_i          (clausesat_i)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Row model: stores what the base writes; an implication drive loads the implied values
  always @(posedge clk) begin
    if (imp_drv_o) begin
      row_val <= row_imp_val;
    end else if (wr_o) begin
      row_val <= var_value_frombase_o;
    end
  end
  assign var_value_tobase_i = row_val;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Run one full evaluation: accept, count strobes, check outcome, then acknowledge
  task automatic applyStimulus(input vec_t v, input string tag);
    int  lat;
    int  n_wr;
    int  n_imp;
    int  n_cc;
    int  n_overlap;
    bit  seen;
    lat = 0; n_wr = 0; n_imp = 0; n_cc = 0; n_overlap = 0; seen = 1'b0;
    @(negedge clk);
    checkOutput({tag, " ready_before"}, 32'(ready_o), 32'd1);
    var_value_i       = v.vin;
    clausesat_i       = v.sat;
    freelitcnt_next_i = v.flc;
    cclause_i         = v.cclause;
    row_imp_val       = v.imp_val;
    start_i           = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      start_i = 1'b0;
      n_wr  += int'(wr_o);
      n_imp += int'(imp_drv_o);
      n_cc  += int'(cclause_drv_o);
      if ((int'(wr_o) + int'(imp_drv_o) + int'(cclause_drv_o)) > 1) n_overlap++;
      if (done_o) begin
        lat  = k;
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      checkOutput({tag, " done_timeout"}, 32'd0, 32'd1);
      return;
    end
    if (v.exp_res == RES_IMP && imp_model < CNT_MAX) imp_model++;
    if (v.exp_res == RES_CONF && conf_model < CNT_MAX) conf_model++;
    checkOutput({tag, " latency"}, 32'(lat), 32'(v.exp_lat));
    checkOutput({tag, " result"}, 32'(result_o), 32'(v.exp_res));
    checkOutput({tag, " value"}, 32'(var_value_o), 32'(v.exp_val));
    checkOutput({tag, " wr_pulses"}, 32'(n_wr), 32'd1);
    checkOutput({tag, " imp_pulses"}, 32'(n_imp), (v.exp_res == RES_IMP) ? 32'd1 : 32'd0);
    checkOutput({tag, " cclause_pulses"}, 32'(n_cc), (v.exp_res == RES_CONF) ? 32'd1 : 32'd0);
    checkOutput({tag, " strobe_overlap"}, 32'(n_overlap), 32'd0);
    checkOutput({tag, " imp_cnt"}, 32'(imp_cnt_o), 32'(imp_model));
    checkOutput({tag, " conf_cnt"}, 32'(conf_cnt_o), 32'(conf_model));
    checkOutput({tag, " err"}, 32'(err_o), 32'(v.exp_err));
    @(negedge clk);
    checkOutput({tag, " done_held"}, 32'(done_o), 32'd1);
    checkOutput({tag, " result_held"}, 32'(result_o), 32'(v.exp_res));
    done_ack_i = 1'b1;
    @(negedge clk);
    done_ack_i = 1'b0;
    checkOutput({tag, " done_cleared"}, 32'(done_o), 32'd0);
    checkOutput({tag, " ready_after"}, 32'(ready_o), 32'd1);
  endtask

  // Wait (bounded) for done_o at negedges; reports a timeout as a failed comparison
  task automatic waitDone(input string tag);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done_o) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) checkOutput({tag, " done_timeout"}, 32'd0, 32'd1);
  endtask

  // Hard stop in case anything hangs
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main sequence: reset, vector table, then the multi-cycle corner cases
  initial begin
    rst = 1'b1; start_i = 1'b0; done_ack_i = 1'b0; var_value_i = '0;
    clausesat_i = 1'b0; freelitcnt_next_i = FLC_MANY; cclause_i = 1'b0;
    row_imp_val = '0;

    //           vin      sat   flc   ccl   imp_val  res        lat val      err
    vecs[0] = '{12'h111, 1'b1, 2'd2, 1'b0, 12'h000, RES_SAT,   3, 12'h111, 1'b0};
    vecs[1] = '{12'h321, 1'b0, 2'd1, 1'b0, 12'hA5C, RES_IMP,   5, 12'hA5C, 1'b0};
    vecs[2] = '{12'h456, 1'b0, 2'd0, 1'b1, 12'h000, RES_CONF,  4, 12'h456, 1'b0};
    vecs[3] = '{12'h123, 1'b0, 2'd2, 1'b0, 12'h000, RES_UNDET, 3, 12'h123, 1'b0};
    vecs[4] = '{12'h777, 1'b1, 2'd0, 1'b1, 12'h000, RES_SAT,   3, 12'h777, 1'b0};
    vecs[5] = '{12'hBBB, 1'b0, 2'd1, 1'b0, 12'h9E1, RES_IMP,   5, 12'h9E1, 1'b0};
    vecs[6] = '{12'h246, 1'b0, 2'd0, 1'b0, 12'h000, RES_CONF,  4, 12'h246, 1'b1};
    vecs[7] = '{12'h135, 1'b0, 2'd2, 1'b0, 12'h000, RES_UNDET, 3, 12'h135, 1'b1};
    v_imp     = vecs[1];
    v_illegal = '{12'h5A5, 1'b0, 2'd3, 1'b0, 12'h000, RES_UNDET, 3, 12'h5A5, 1'b1};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("reset ready", 32'(ready_o), 32'd1);
    checkOutput("reset done", 32'(done_o), 32'd0);
    checkOutput("reset result", 32'(result_o), 32'd0);
    checkOutput("reset value", 32'(var_value_o), 32'd0);
    checkOutput("reset frombase", 32'(var_value_frombase_o), 32'd0);
    checkOutput("reset strobes", 32'({wr_o, imp_drv_o, cclause_drv_o}), 32'd0);
    checkOutput("reset counters", 32'({imp_cnt_o, conf_cnt_o}), 32'd0);
    checkOutput("reset err", 32'(err_o), 32'd0);
    checkOutput("freelitcnt_pre", 32'(freelitcnt_pre_o), 32'd0);

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i], $sformatf("vec%0d", i));
    end

    // start_i held through DONE must not be accepted until after done_ack_i
    @(negedge clk);
    var_value_i = 12'h0F0; clausesat_i = 1'b0; freelitcnt_next_i = FLC_MANY;
    start_i = 1'b1;
    waitDone("hold");
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("hold ready_in_done", 32'(ready_o), 32'd0);
      checkOutput("hold done_stays", 32'(done_o), 32'd1);
      checkOutput("hold no_wr", 32'(wr_o), 32'd0);
    end
    done_ack_i = 1'b1;
    @(negedge clk);
    done_ack_i = 1'b0;
    checkOutput("hold done_cleared", 32'(done_o), 32'd0);
    checkOutput("hold ready_idle", 32'(ready_o), 32'd1);
    @(negedge clk);
    start_i = 1'b0;
    checkOutput("hold reaccept_wr", 32'(wr_o), 32'd1);
    waitDone("hold2");
    checkOutput("hold2 result", 32'(result_o), 32'(RES_UNDET));
    checkOutput("hold2 value", 32'(var_value_o), 32'h0F0);
    done_ack_i = 1'b1;
    @(negedge clk);
    done_ack_i = 1'b0;

    // Reset while imp_drv_o is high: outputs clear immediately
    @(negedge clk);
    var_value_i = 12'h321; clausesat_i = 1'b0; freelitcnt_next_i = FLC_ONE;
    row_imp_val = 12'hA5C; start_i = 1'b1;
    begin
      bit seen_imp;
      seen_imp = 1'b0;
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        start_i = 1'b0;
        if (imp_drv_o) begin
          seen_imp = 1'b1;
          break;
        end
      end
      if (!seen_imp) checkOutput("rstimp imp_timeout", 32'd0, 32'd1);
    end
    rst = 1'b1;
    #1;
    checkOutput("rstimp imp_drv", 32'(imp_drv_o), 32'd0);
    checkOutput("rstimp done", 32'(done_o), 32'd0);
    checkOutput("rstimp imp_cnt", 32'(imp_cnt_o), 32'd0);
    checkOutput("rstimp conf_cnt", 32'(conf_cnt_o), 32'd0);
    checkOutput("rstimp value", 32'(var_value_o), 32'd0);
    checkOutput("rstimp err", 32'(err_o), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    imp_model = 0;
    conf_model = 0;
    @(negedge clk);
    checkOutput("rstimp ready_after", 32'(ready_o), 32'd1);

    // Illegal freelitcnt value flags an error and reports undetermined
    checkOutput("illegal err_before", 32'(err_o), 32'd0);
    applyStimulus(v_illegal, "illegal");

    // Four implications on a 2-bit counter: count sticks at 3
    for (int r = 0; r < 4; r++) begin
      v_imp.exp_err = 1'b1;
      applyStimulus(v_imp, $sformatf("satrun%0d", r));
    end
    checkOutput("sat imp_cnt_final", 32'(imp_cnt_o), 32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/clause_eval_ctrl.md
Name: clause_eval_ctrl

Overview:
- Base-side driver for one lit4 clause row in a bin.
- Accepts a variable-value vector from the variable base and writes it into the row.
- Reads back the freelitcnt chain and clause-sat result, then decides sat / implication / conflict.
- Fires imp_drv or cclause_drv accordingly and returns the updated value vector and the outcome to the base through a start/done handshake.

Parameters:
- NUM_LITS, 4: literals in the driven row; 3 bits per literal.
- CNT_W, 16: width of the saturating implication and conflict counters.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- start_i  in  1  base requests an evaluation.
- ready_o  out  1  controller idle; start_i is accepted when start_i & ready_o.
- var_value_i  in  NUM_LITS*3  value vector from the base, captured at accept.
- done_o  out  1  result valid; held until done_ack_i.
- done_ack_i  in  1  base consumes the result.
- result_o  out  2  outcome: 00 undetermined, 01 sat, 10 implied, 11 conflict.
- var_value_o  out  NUM_LITS*3  vector returned to the base.
- err_o  out  1  sticky protocol error.
- imp_cnt_o  out  CNT_W  saturating count of implied results.
- conf_cnt_o  out  CNT_W  saturating count of conflict results.
- wr_o  out  1  write strobe to the row.
- var_value_frombase_o  out  NUM_LITS*3  values written into the row.
- var_value_tobase_i  in  NUM_LITS*3  values read back from the row.
- freelitcnt_pre_o  out  2  head of the freelitcnt chain; constant 2'b00.
- freelitcnt_next_i  in  2  tail of the chain: 0, 1, or 2 (2 means two or more free).
- imp_drv_o  out  1  implication drive to the row.
- cclause_i  in  1  row reports conflict clause.
- cclause_drv_o  out  1  conflict-clause drive to the row.
- clausesat_i  in  1  row reports clause satisfied.

Behaviour:
- Reset (async, active-high):
  - State IDLE.
  - ready_o=1.
  - All other outputs 0, including counters, err_o and the value registers.
- Value register vreg: captured from var_value_i at accept; drives both var_value_frombase_o and var_value_o.
- States and transitions:
  - IDLE: ready_o=1. On start_i, capture vreg and go to LOAD.
  - LOAD (1 cycle): wr_o=1; go to EVAL.
  - EVAL (1 cycle): sample clausesat_i and freelitcnt_next_i, which are combinational from the row's registered state. Priority order:
    - clausesat_i=1 -> DONE, result 01.
    - else freelitcnt_next_i==0 -> CONF.
    - else freelitcnt_next_i==1 -> IMP.
    - else (2) -> DONE, result 00.
    - freelitcnt_next_i==3 is illegal: set err_o, then DONE with result 00.
  - IMP (1 cycle): imp_drv_o=1; go to IMP_CAP.
  - IMP_CAP (1 cycle): vreg <= var_value_tobase_i; imp_cnt_o++ (saturating at all-ones); go to DONE, result 10.
  - CONF (1 cycle): cclause_drv_o=1. If cclause_i=0 this cycle, set err_o. conf_cnt_o++ (saturating); go to DONE, result 11.
  - DONE: done_o=1; result_o and var_value_o stable. On done_ack_i go to IDLE, clearing done_o next cycle. done_ack_i outside DONE is ignored.
- Latency from accept edge to done_o:
  - 3 cycles for sat / undetermined.
  - 4 cycles for conflict.
  - 5 cycles for implied.
- Protocol rules:
  - start_i while not IDLE is ignored, with no queueing.
  - start_i in the same cycle as done_ack_i is not accepted (ready_o=0 in DONE).
  - imp_drv_o, cclause_drv_o and wr_o are single-cycle pulses and mutually exclusive.
- err_o is sticky until reset.
- Reset asserted mid-operation: immediate return to IDLE. Any pending drive pulse is cut and vreg is cleared.

Decomposition:
- Shared package sat_bin_pkg holds:
  - RES_UNDET, RES_SAT, RES_IMP, RES_CONF constants.
  - 3-bit LIT_VAL_W.
  - The freelitcnt encoding constants.
  - The state enum.
- One sub-module, sat_cnt: saturating CNT_W counter with inc and async rst; instantiated twice.

Test Plan:
- Sat path: start with clausesat_i=1 at EVAL -> done_o 3 cycles after accept; result 01; no imp_drv_o or cclause_drv_o pulse.
- Implication path: freelitcnt_next_i=1, clausesat_i=0, and the row model returns 12'hA5C after imp_drv_o -> exactly one imp_drv_o pulse; done at +5 with result 10; var_value_o=12'hA5C; imp_cnt_o=1.
- Conflict path: freelitcnt_next_i=0 with cclause_i=1 -> one cclause_drv_o pulse; result 11; conf_cnt_o=1; err_o=0. Repeat with cclause_i=0 -> err_o=1 and stays 1.
- Undetermined path: freelitcnt_next_i=2 -> result 00; var_value_o equals the captured input 12'h123. Also, start_i held high during DONE is not accepted until after done_ack_i.
- Reset mid-IMP: assert rst while imp_drv_o=1 -> imp_drv_o, done_o and counters are 0 in the same cycle; ready_o=1 after release.
- Counter saturation with CNT_W=2: four implication runs -> imp_cnt_o sticks at 3.
